// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: memory width encodings, the FSM
// state type, the command/control record and the beat-count helpers used to
// split accesses the memory cannot perform natively.
// -----------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } lsu_state_e;

  // One record serves both as the latched command and as the set of memory
  // controls for a single beat, since they carry the same fields.
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    logic        extend;
  } lsu_req_t;

  // Access size in bytes; width 1x is a word.
  function automatic logic [2:0] lsu_size(input logic [1:0] width);
    case (width)
      WIDTH_BYTE: return 3'd1;
      WIDTH_HALF: return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input logic [1:0] width, input logic [1:0] off);
    return ((width == WIDTH_HALF) && off[0]) || (width[1] && (off != 2'b00));
  endfunction

  // Number of memory beats a command needs: split stores go byte by byte,
  // split loads need a second word only when the data spans a word boundary.
  function automatic logic [2:0] lsu_beats(input logic       write,
                                           input logic [1:0] width,
                                           input logic [1:0] off);
    if (!lsu_misaligned(width, off)) return 3'd1;
    if (write) return lsu_size(width);
    return (({2'b00, off} + {1'b0, lsu_size(width)}) > 4'd4) ? 3'd2 : 3'd1;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational merge of up to two aligned memory words into a load result.
// The 64-bit value {word_hi_i, word_lo_i} is shifted right by 8*offset_i, the
// low 1/2/4 bytes are kept according to width_i, and the result is zero- or
// sign-extended according to extend_i.
// Ports:
//   word_hi_i  [31:0]  upper word (0 when there is no second word)
//   word_lo_i  [31:0]  lower word
//   offset_i   [1:0]   byte offset of the access within word_lo_i
//   width_i    [1:0]   access width encoding
//   extend_i           1 = sign-extend
//   result_o   [31:0]  merged, extended load data
// -----------------------------------------------------------------------------
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_hi_i,
  input  logic [31:0] word_lo_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  width_i,
  input  logic        extend_i,
  output logic [31:0] result_o
);

  logic [63:0] pair;
  logic [31:0] window;

  assign pair   = {word_hi_i, word_lo_i};
  assign window = 32'(pair >> {offset_i, 3'b000});

  always_comb begin
    result_o = window;
    case (width_i)
      WIDTH_BYTE: result_o = {{24{extend_i & window[7]}}, window[7:0]};
      WIDTH_HALF: result_o = {{16{extend_i & window[15]}}, window[15:0]};
      default:    result_o = window;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Initiator side of the data-memory req/ack port. Accepts load/store commands
// over a valid/ready handshake, splits misaligned halfword/word accesses into
// aligned beats, and returns a one-cycle response per command.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready        command handshake
//   cmd_write, cmd_addr, cmd_wdata, cmd_width, cmd_extend   command fields
//   rsp_valid, rsp_rdata         completion pulse and load data (0 for stores)
//   mem_req, mem_addr, mem_write, mem_wdata, mem_extend, mem_width
//                                registered controls to the memory
//   mem_ack, mem_rdata           memory acknowledge and read data
// -----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [1:0]  cmd_width,
  input  logic        cmd_extend,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  output logic        mem_extend,
  output logic [1:0]  mem_width,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  lsu_req_t    cmd_in;
  lsu_req_t    cmd_q, cmd_d;
  lsu_req_t    mem_q, mem_d;
  logic [1:0]  beat_q, beat_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] lo_q, lo_d;
  logic        req_q, req_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        beat_last;
  logic [31:0] align_hi, align_lo, align_result;

  // Memory controls for beat k of command c. Aligned commands pass through
  // unchanged; split stores become byte stores at addr+k carrying byte k;
  // split loads become word reads at the aligned base and base+4.
  function automatic lsu_req_t beat_ctrl(input lsu_req_t c, input logic [1:0] k);
    lsu_req_t b;
    b = c;
    if (lsu_misaligned(c.width, c.addr[1:0])) begin
      b.extend = 1'b0;
      if (c.write) begin
        b.addr  = c.addr + {30'd0, k};
        b.width = WIDTH_BYTE;
        b.wdata = {24'd0, c.wdata[{k, 3'b000} +: 8]};
      end else begin
        b.addr  = {c.addr[31:2], 2'b00} + {29'd0, k[0], 2'b00};
        b.width = WIDTH_WORD;
        b.wdata = 32'd0;
      end
    end
    return b;
  endfunction

  assign cmd_in    = {cmd_write, cmd_addr, cmd_wdata, cmd_width, cmd_extend};
  assign beat_last = (beat_q == last_q);

  // A two-beat load merges the captured low word with the word now on the
  // bus; a single-beat split load has only the word on the bus.
  assign align_hi = (beat_q != 2'd0) ? mem_rdata : 32'd0;
  assign align_lo = (beat_q != 2'd0) ? lo_q      : mem_rdata;

  lsu_load_align u_align (
    .word_hi_i (align_hi),
    .word_lo_i (align_lo),
    .offset_i  (cmd_q.addr[1:0]),
    .width_i   (cmd_q.width),
    .extend_i  (cmd_q.extend),
    .result_o  (align_result)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = ACCESS;
      ACCESS:  if (mem_ack && beat_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    cmd_ready   = (state_q == IDLE);
    cmd_d       = cmd_q;
    mem_d       = mem_q;
    beat_d      = beat_q;
    last_d      = last_q;
    lo_d        = lo_q;
    req_d       = req_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d  = cmd_in;
          beat_d = 2'd0;
          last_d = 2'(lsu_beats(cmd_write, cmd_width, cmd_addr[1:0]) - 3'd1);
          mem_d  = beat_ctrl(cmd_in, 2'd0);
          req_d  = 1'b1;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          if (beat_last) begin
            req_d       = 1'b0;
            rsp_valid_d = 1'b1;
            if (cmd_q.write)
              rsp_rdata_d = 32'd0;
            else if (lsu_misaligned(cmd_q.width, cmd_q.addr[1:0]))
              rsp_rdata_d = align_result;
            else
              rsp_rdata_d = mem_rdata;
          end else begin
            // req stays high so the new controls start the next beat directly
            lo_d   = mem_rdata;
            beat_d = beat_q + 2'd1;
            mem_d  = beat_ctrl(cmd_q, beat_q + 2'd1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q       <= '0;
      mem_q       <= '0;
      beat_q      <= 2'd0;
      last_q      <= 2'd0;
      lo_q        <= 32'd0;
      req_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      cmd_q       <= cmd_d;
      mem_q       <= mem_d;
      beat_q      <= beat_d;
      last_q      <= last_d;
      lo_q        <= lo_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign mem_req    = req_q;
  assign mem_addr   = mem_q.addr;
  assign mem_write  = mem_q.write;
  assign mem_wdata  = mem_q.wdata;
  assign mem_extend = mem_q.extend;
  assign mem_width  = mem_q.width;

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_extend;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [1:0]  cmd_width;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_write, mem_extend, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_width;

  load_store_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_width  (cmd_width),
    .cmd_extend (cmd_extend),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_extend (mem_extend),
    .mem_width  (mem_width),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    int          due;
  } rsp_t;

  rsp_t        exp_rsp[$];
  logic [67:0] exp_acc[$];
  logic [31:0] mem [0:255];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          rsp_seen = 0;
  logic        stray_pending;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic logic [67:0] acc(input logic [31:0] a, input logic [31:0] d,
                                      input logic w, input logic e, input logic [1:0] wd);
    return {a, d, w, e, wd};
  endfunction

  // Memory read as the memory port performs it: lane select plus extension.
  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [1:0] w, input logic e);
    logic [31:0] wd;
    wd = mem[a[9:2]] >> {a[1:0], 3'b000};
    case (w)
      2'b00:   return {{24{e & wd[7]}}, wd[7:0]};
      2'b01:   return {{16{e & wd[15]}}, wd[15:0]};
      default: return wd;
    endcase
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
    case (w)
      2'b00:   mem[a[9:2]][{a[1:0], 3'b000} +: 8]  = d[7:0];
      2'b01:   mem[a[9:2]][{a[1:0], 3'b000} +: 16] = d[15:0];
      default: mem[a[9:2]] = d;
    endcase
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] w, input logic e,
                       input logic [31:0] exp_rd, input int lat, input logic hold);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", 72'(cmd_ready), 72'(1));
    cmd_valid  = 1'b1;
    cmd_write  = wr;
    cmd_addr   = a;
    cmd_wdata  = d;
    cmd_width  = w;
    cmd_extend = e;
    exp_rsp.push_back('{exp_rd, cyc + 1 + lat});
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (exp_rsp.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_timeout", 72'(exp_rsp.size()), 72'(0));
  endtask

  initial begin
    int seen0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_width = 2'b00; cmd_extend = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; stray_pending = 1'b0;
    reset_n = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;

    fork
      // Memory responder: acks the edge after it samples req & ~ack.
      forever begin
        @(posedge clk);
        if (mem_ack) begin
          mem_ack <= 1'b0;
        end else if (mem_req) begin
          if (mem_write) mem_wr(mem_addr, mem_wdata, mem_width);
          else mem_rdata <= mem_rd(mem_addr, mem_width, mem_extend);
          mem_ack <= 1'b1;
        end else if (stray_pending) begin
          mem_ack       <= 1'b1;
          mem_rdata     <= 32'hBAD0BAD0;
          stray_pending = 1'b0;
        end
      end
      // Access monitor: every new beat is checked against the expected list.
      forever begin
        @(negedge clk);
        if (reset_n && mem_req && !mem_ack) begin
          chk("access_expected", 72'(exp_acc.size() != 0), 72'(1));
          if (exp_acc.size() != 0)
            chk("access", 72'({mem_addr, mem_wdata, mem_write, mem_extend, mem_width}),
                72'(exp_acc.pop_front()));
        end
      end
      // Response monitor
      forever begin
        @(negedge clk);
        if (rsp_valid) begin
          rsp_t r;
          rsp_seen++;
          chk("rsp_expected", 72'(exp_rsp.size() != 0), 72'(1));
          if (exp_rsp.size() != 0) begin
            r = exp_rsp.pop_front();
            chk("rsp_rdata", 72'(rsp_rdata), 72'(r.rdata));
            chk("rsp_latency", 72'(cyc), 72'(r.due));
            chk("ready_with_rsp", 72'(cmd_ready), 72'(1));
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", 72'(cmd_ready), 72'(1));
    chk("reset_mem_req", 72'(mem_req), 72'(0));
    chk("reset_rsp_valid", 72'(rsp_valid), 72'(0));
    chk("reset_rsp_rdata", 72'(rsp_rdata), 72'(0));
    chk("reset_mem_ctrl", 72'({mem_addr, mem_wdata, mem_write, mem_extend, mem_width}), 72'(0));

    // Aligned word load
    mem[8'h40] = 32'hDEADBEEF;
    exp_acc.push_back(acc(32'h100, 32'h0, 1'b0, 1'b0, 2'b10));
    issue(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 2, 1'b0);
    wait_done(20);

    // Signed and unsigned byte load at offset 3
    mem[8'h40] = 32'h80FF0000;
    exp_acc.push_back(acc(32'h103, 32'h0, 1'b0, 1'b1, 2'b00));
    issue(1'b0, 32'h103, 32'h0, 2'b00, 1'b1, 32'hFFFFFF80, 2, 1'b0);
    wait_done(20);
    exp_acc.push_back(acc(32'h103, 32'h0, 1'b0, 1'b0, 2'b00));
    issue(1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 32'h00000080, 2, 1'b0);
    wait_done(20);

    // Misaligned word load spanning two words; req must stay high throughout
    mem[8'h40] = 32'h44332211;
    mem[8'h41] = 32'h88776655;
    exp_acc.push_back(acc(32'h100, 32'h0, 1'b0, 1'b0, 2'b10));
    exp_acc.push_back(acc(32'h104, 32'h0, 1'b0, 1'b0, 2'b10));
    issue(1'b0, 32'h102, 32'h0, 2'b10, 1'b0, 32'h66554433, 4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("split_req_held", 72'(mem_req), 72'(1));
    end
    wait_done(20);

    // Misaligned halfword load inside one word, sign-extended
    mem[8'hC0] = 32'h1280F034;
    mem[8'hC1] = 32'hAABBCCDD;
    exp_acc.push_back(acc(32'h300, 32'h0, 1'b0, 1'b0, 2'b10));
    issue(1'b0, 32'h301, 32'h0, 2'b01, 1'b1, 32'hFFFF80F0, 2, 1'b0);
    wait_done(20);

    // Misaligned halfword load crossing a word, zero-extended
    exp_acc.push_back(acc(32'h300, 32'h0, 1'b0, 1'b0, 2'b10));
    exp_acc.push_back(acc(32'h304, 32'h0, 1'b0, 1'b0, 2'b10));
    issue(1'b0, 32'h303, 32'h0, 2'b01, 1'b0, 32'h0000DD12, 4, 1'b0);
    wait_done(20);

    // Misaligned halfword store split into two byte stores
    mem[8'h80] = 32'h11223344;
    mem[8'h81] = 32'h55667788;
    exp_acc.push_back(acc(32'h203, 32'h000000EF, 1'b1, 1'b0, 2'b00));
    exp_acc.push_back(acc(32'h204, 32'h000000BE, 1'b1, 1'b0, 2'b00));
    issue(1'b1, 32'h203, 32'h1234BEEF, 2'b01, 1'b0, 32'h0, 4, 1'b0);
    wait_done(20);
    chk("store_half_w200", 72'(mem[8'h80]), 72'(32'hEF223344));
    chk("store_half_w204", 72'(mem[8'h81]), 72'(32'h556677BE));

    // Misaligned word store split into four byte stores
    exp_acc.push_back(acc(32'h205, 32'h000000D4, 1'b1, 1'b0, 2'b00));
    exp_acc.push_back(acc(32'h206, 32'h000000C3, 1'b1, 1'b0, 2'b00));
    exp_acc.push_back(acc(32'h207, 32'h000000B2, 1'b1, 1'b0, 2'b00));
    exp_acc.push_back(acc(32'h208, 32'h000000A1, 1'b1, 1'b0, 2'b00));
    issue(1'b1, 32'h205, 32'hA1B2C3D4, 2'b10, 1'b0, 32'h0, 8, 1'b0);
    wait_done(30);
    chk("store_word_w204", 72'(mem[8'h81]), 72'(32'hB2C3D4BE));
    chk("store_word_w208", 72'(mem[8'h82]), 72'(32'h000000A1));

    // Aligned halfword store passes through untouched
    exp_acc.push_back(acc(32'h20A, 32'hFFFF5A5A, 1'b1, 1'b0, 2'b01));
    issue(1'b1, 32'h20A, 32'hFFFF5A5A, 2'b01, 1'b0, 32'h0, 2, 1'b0);
    wait_done(20);
    chk("store_aligned_w208", 72'(mem[8'h82]), 72'(32'h5A5A00A1));

    // Back-to-back commands with cmd_valid held high
    exp_acc.push_back(acc(32'h100, 32'h0, 1'b0, 1'b0, 2'b10));
    exp_acc.push_back(acc(32'h104, 32'h0, 1'b0, 1'b0, 2'b10));
    exp_acc.push_back(acc(32'h100, 32'h0, 1'b0, 1'b0, 2'b10));
    exp_acc.push_back(acc(32'h104, 32'h0, 1'b0, 1'b0, 2'b10));
    issue(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 32'h44332211, 2, 1'b1);
    issue(1'b0, 32'h104, 32'h0, 2'b10, 1'b0, 32'h88776655, 2, 1'b1);
    issue(1'b0, 32'h102, 32'h0, 2'b10, 1'b0, 32'h66554433, 4, 1'b0);
    wait_done(30);
    repeat (3) @(negedge clk);
    chk("b2b_access_drained", 72'(exp_acc.size()), 72'(0));

    // Reset in the middle of a split load
    exp_acc.push_back(acc(32'h100, 32'h0, 1'b0, 1'b0, 2'b10));
    exp_acc.push_back(acc(32'h104, 32'h0, 1'b0, 1'b0, 2'b10));
    issue(1'b0, 32'h102, 32'h0, 2'b10, 1'b0, 32'h66554433, 4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midreset_mem_req", 72'(mem_req), 72'(0));
    chk("midreset_rsp_valid", 72'(rsp_valid), 72'(0));
    exp_rsp.delete();
    exp_acc.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen0 = rsp_seen;
    stray_pending = 1'b1;
    repeat (5) @(negedge clk);
    chk("stray_ack_no_rsp", 72'(rsp_seen - seen0), 72'(0));
    chk("stray_ack_no_req", 72'(mem_req), 72'(0));
    exp_acc.push_back(acc(32'h300, 32'h0, 1'b0, 1'b0, 2'b10));
    issue(1'b0, 32'h300, 32'h0, 2'b10, 1'b0, 32'h1280F034, 2, 1'b0);
    wait_done(20);

    repeat (3) @(negedge clk);
    chk("final_rsp_queue", 72'(exp_rsp.size()), 72'(0));
    chk("final_acc_queue", 72'(exp_acc.size()), 72'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory req/ack port. It accepts load/store commands from the execute stage over a valid/ready handshake and drives the memory's `req`/`addr`/`write_in`/`data_in`/`extend`/`width` signals. Accesses the memory cannot perform natively (misaligned halfword/word) are split into a sequence of aligned accesses. It returns one response pulse per command, carrying merged and extended load data.

## Interface
No parameters; all widths are fixed by the memory port.
- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready` at a rising edge
- `cmd_write`  in  1  1 = store, 0 = load
- `cmd_addr`  in  32  byte address
- `cmd_wdata`  in  32  store data, right-aligned
- `cmd_width`  in  2  00 byte, 01 half, 10/11 word
- `cmd_extend`  in  1  sign-extend load result
- `rsp_valid`  out  1  one-cycle pulse, command complete
- `rsp_rdata`  out  32  load result, valid with `rsp_valid`; 0 for stores
- `mem_req`  out  1  to memory `req`
- `mem_addr`  out  32  to memory `addr`
- `mem_write`  out  1  to memory `write_in`
- `mem_wdata`  out  32  to memory `data_in`
- `mem_extend`  out  1  to memory `extend`
- `mem_width`  out  2  to memory `width`
- `mem_ack`  in  1  from memory `ack`
- `mem_rdata`  in  32  from memory `data_out`, valid while `mem_ack`=1

## Operation
- **Size and offset.** Size N = 1/2/4 bytes from `cmd_width`. Offset o = `cmd_addr[1:0]`.
- **Misalignment.** A command is misaligned when width=01 with o odd, or width=1x with o≠0.
- **Aligned command.** One access. `mem_addr`, `mem_width`, `mem_extend`, `mem_write` and `mem_wdata` are copied from the command. `rsp_rdata` is `mem_rdata`.
- **Misaligned load.**
  - Beat 0 reads the word at A0 = `cmd_addr & ~3` (width 10).
  - Beat 1 is issued only when o+N > 4. It reads the word at A0+4, modulo 2^32.
  - The 64-bit value {hi, lo} is shifted right by 8·o and the low N bytes are kept. The result is zero- or sign-extended per `cmd_extend`. hi = 0 when there is no beat 1.
- **Misaligned store.** N byte stores (width 00) to `cmd_addr`+k, k = 0..N-1, mod 2^32. Beat k carries data byte `cmd_wdata[8k+7:8k]` in `mem_wdata[7:0]`.
- **States.**
  - IDLE: `cmd_ready`=1. On accept, latch the command and go to ACCESS with beat counter = 0 and total beats computed.
  - ACCESS: hold `mem_req`=1 and stable controls until `mem_ack`.
    - On an ack that is not the last beat: capture the load word, increment the beat, and update the controls at that edge with `mem_req` kept high.
    - On the ack of the last beat: `mem_req`←0, `rsp_valid`←1, `rsp_rdata`←result, go to IDLE.
- **Unsolicited ack.** `mem_ack` seen in IDLE is ignored.
- **Reset values.** `mem_req`=0, `rsp_valid`=0, `rsp_rdata`=0, `mem_*` controls=0, state IDLE, and `cmd_ready`=1 once reset is released.
- **Reset mid-operation.** The command is abandoned and no response is produced. Memory contents after a partially completed split store are unspecified.

## Timing
- **Memory handshake rules.**
  - The memory acks on the edge after it samples `req & ~ack`, and drops ack on the following edge.
  - `mem_req` and the `mem_*` controls are registered.
  - The controls may change only at an edge where `mem_ack`=1, or on command accept.
  - Keeping `mem_req` high across an ack edge starts the next beat with no double-ack.
- **Cycle counts.**
  - Each beat takes 2 cycles from `mem_req` rising (or controls updating) to the ack edge.
  - Aligned command: accept at edge E0, `mem_ack` high after E1, `rsp_valid` high in the cycle after E2.
  - Split command: latency = 2·beats edges from accept to `rsp_valid`.
- **Throughput.** `cmd_ready` is low from the accept edge until the cycle after `rsp_valid`; `rsp_valid` and `cmd_ready` are both high in that cycle. One aligned command per 3 cycles maximum.
- **Combinational paths.** No combinational path from `mem_ack` to any output.

## Structure
- **Shared package `lsu_pkg`:**
  - width encodings: WIDTH_BYTE=2'b00, WIDTH_HALF=2'b01, WIDTH_WORD=2'b10
  - state enum: IDLE, ACCESS
  - a beat-count helper function
- **Sub-module `lsu_load_align`** (combinational): inputs {hi, lo}, offset, width, extend; output 32-bit result. It is shared with any future cache path.
- **Top module:** FSM, beat counter (2 bits), latched command, captured low word.

## Test plan
- **Aligned word load** of addr 0x100 holding 0xDEADBEEF → one access with `mem_width`=10; `rsp_rdata`=0xDEADBEEF; `rsp_valid` two edges after accept.
- **Signed byte load** at 0x103, memory word 0x80FF0000, extend=1 → single access; `rsp_rdata`=0xFFFFFF80. With extend=0 → 0x00000080.
- **Misaligned word load** at 0x102, words 0x44332211 at 0x100 and 0x88776655 at 0x104 → two word reads at 0x100 then 0x104 with `mem_req` continuously high; `rsp_rdata`=0x66554433; latency 4 edges.
- **Misaligned halfword store** of 0xBEEF at 0x203 → byte stores 0xEF@0x203, then 0xBE@0x204; the words at 0x200 and 0x204 change only in those bytes.
- **Back-to-back commands** with `cmd_valid` held high → exactly one `mem_ack` per beat and no spurious repeated access.
- **Reset during a split load** → `mem_req` and `rsp_valid` drop immediately; a stray `mem_ack` afterwards produces no response; the next command completes normally.
